execute_cycle: RTL and testbench
================================

# execute_cycle

Execute stage of the 5-stage RV32I pipeline. Consumes the ID/EX register outputs of the decode stage, selects ALU operands (with optional forwarding), computes the ALU result, and resolves BEQ-style branches and their target. Results and surviving control signals are latched into the EX/MEM pipeline register that feeds the memory stage.

## Interface
- No parameters; datapath fixed at 32 bits, register index at 5 bits.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  in  1 each  control bits from ID/EX.
- ALUControlE  in  3  ALU operation select.
- RD1_E, RD2_E  in  32  register-file operands.
- Imm_Ext_E  in  32  sign-extended immediate.
- RD_E  in  5  destination register index.
- PCE, PCPlus4E  in  32  instruction PC and PC+4.
- ForwardA_E, ForwardB_E  in  2  forwarding selects from the hazard unit (used only with EXEC_FWD_EN).
- ResultW  in  32  write-back result (forwarding source).
- PCSrcE  out  1  branch taken, combinational.
- PCTargetE  out  32  PCE + Imm_Ext_E, combinational.
- RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered control to memory stage.
- RD_M  out  5  registered destination index.
- ALU_ResultM  out  32  registered ALU result.
- WriteDataM  out  32  registered store data (forwarded operand B, pre-immediate mux).
- PCPlus4M  out  32  registered PC+4.

## Operation
- SrcA = forwarded A. Forwarding mux: 2'b00 → RD1_E, 2'b01 → ResultW, 2'b10 → ALU_ResultM (current EX/MEM register contents), 2'b11 → RD1_E. Same mux on B with RD2_E.
- SrcB = ALUSrcE ? Imm_Ext_E : forwarded B.
- ALUControlE: 000 add, 001 sub, 010 and, 011 or, 101 slt (signed; result 32'h1 or 32'h0). 100/110/111 → result 32'h0.
- Add/sub wrap modulo 2^32; no overflow flag, no exception.
- Zero = (ALU result == 0), internal only.
- PCSrcE = BranchE & Zero, forced 0 while rst is low.
- PCTargetE = PCE + Imm_Ext_E, modulo 2^32, always driven regardless of BranchE.
- No internal state beyond the EX/MEM register; no stall or flush inputs (bubbles are injected upstream as all-zero control).

## Timing
- EX/MEM register loads every rising clk edge when rst high: one-cycle latency from E inputs to all M outputs.
- PCSrcE and PCTargetE: zero-cycle (combinational from current E inputs and ALU_ResultM).
- Forward select 2'b10 returns the value latched on the previous edge (back-to-back dependency); 2'b01 returns ResultW of the same cycle.
- Reset (rst low, any time, asynchronous): RegWriteM, MemWriteM, ResultSrcM = 0; RD_M = 5'h00; ALU_ResultM, WriteDataM, PCPlus4M = 32'h0. Reset asserted mid-instruction discards it; no partial update.
- First edge after rst deasserts captures the then-present E inputs normally.

## Configuration
- EXEC_FWD_EN defined: forwarding muxes as above.
- EXEC_FWD_EN undefined: ForwardA_E, ForwardB_E, ResultW ignored; SrcA = RD1_E, forwarded B = RD2_E; all other behaviour identical. Ports remain present in both builds.

## Test plan
- Reset: hold rst low with nonzero inputs, toggle clk → all M outputs 0, PCSrcE 0; release → next edge captures inputs.
- ADD/SUB/SLT: RD1_E=32'hFFFF_FFFF, RD2_E=1, ALUSrcE=0; ALUControlE 000 → ALU_ResultM 32'h0 after one edge; 001 → 32'hFFFF_FFFE; 101 → 32'h1 (signed −1 < 1).
- Immediate path + store data: RD1_E=100, RD2_E=7, Imm_Ext_E=20, ALUSrcE=1, MemWriteE=1, add → ALU_ResultM=120, WriteDataM=7, MemWriteM=1.
- Branch: BranchE=1, RD1_E=RD2_E=5, sub, PCE=32'h40, Imm_Ext_E=32'hFFFF_FFF8 → PCSrcE=1, PCTargetE=32'h38 same cycle; RD2_E=6 → PCSrcE=0.
- Forwarding (EXEC_FWD_EN): cycle 1 add 3+4 latches ALU_ResultM=7; cycle 2 ForwardA_E=10, RD2_E=1, add → ALU_ResultM=8; ForwardB_E=01, ResultW=9 → WriteDataM=9. Without macro same stimulus uses RD1_E/RD2_E.
- Undefined op: ALUControlE=110, operands 5 and 3 → ALU_ResultM=0; with BranchE=1 → PCSrcE=1.

Source files
------------

// File: rtl/execute_cycle.sv
// Execute stage of the RV32I pipeline: operand forwarding, ALU, branch resolution, EX/MEM register.
// Build option EXEC_FWD_EN enables the ForwardA_E/ForwardB_E operand muxes; otherwise RD1_E/RD2_E are used directly.
module execute_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        ALUSrcE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        BranchE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [4:0]  RD_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    input  logic [31:0] ResultW,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] ALU_ResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCPlus4M
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [31:0] src_a;
    logic [31:0] fwd_b;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic        zero;

    logic        reg_write_q,  reg_write_d;
    logic        mem_write_q,  mem_write_d;
    logic        result_src_q, result_src_d;
    logic [4:0]  rd_q,         rd_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] write_data_q, write_data_d;
    logic [31:0] pc_plus4_q,   pc_plus4_d;

`ifdef EXEC_FWD_EN
    // 2'b10 feeds back the EX/MEM register for back-to-back dependencies
    always_comb begin
        src_a = RD1_E;
        case (ForwardA_E)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = alu_result_q;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        fwd_b = RD2_E;
        case (ForwardB_E)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = alu_result_q;
            default: fwd_b = RD2_E;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{ForwardA_E, ForwardB_E, ResultW};
    assign src_a      = RD1_E;
    assign fwd_b      = RD2_E;
`endif

    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

    always_comb begin
        alu_result = 32'h0;
        case (ALUControlE)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {31'h0, ($signed(src_a) < $signed(src_b))};
            default: alu_result = 32'h0;
        endcase
    end

    assign zero      = (alu_result == 32'h0);
    // Taken-branch is suppressed during reset so fetch never redirects on garbage
    assign PCSrcE    = rst & BranchE & zero;
    assign PCTargetE = PCE + Imm_Ext_E;

    always_comb begin
        reg_write_d  = RegWriteE;
        mem_write_d  = MemWriteE;
        result_src_d = ResultSrcE;
        rd_d         = RD_E;
        alu_result_d = alu_result;
        write_data_d = fwd_b;
        pc_plus4_d   = PCPlus4E;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            rd_q         <= 5'h00;
            alu_result_q <= 32'h0;
            write_data_q <= 32'h0;
            pc_plus4_q   <= 32'h0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
        end
    end

    assign RegWriteM   = reg_write_q;
    assign MemWriteM   = mem_write_q;
    assign ResultSrcM  = result_src_q;
    assign RD_M        = rd_q;
    assign ALU_ResultM = alu_result_q;
    assign WriteDataM  = write_data_q;
    assign PCPlus4M    = pc_plus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: directed vector table, reset sequences, and randomized vectors against a reference model.
module tb_execute_cycle;

    typedef struct {
        logic        regw, alusrc, memw, ressrc, br;
        logic [2:0]  op;
        logic [31:0] a, b, imm, pc, pc4, resw;
        logic [4:0]  rd;
        logic [1:0]  fa, fb;
        logic        exp_pcsrc;
        logic [31:0] exp_tgt, exp_alu, exp_wd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RegWriteE = 0, ALUSrcE = 0, MemWriteE = 0, ResultSrcE = 0, BranchE = 0;
    logic [2:0]  ALUControlE = 0;
    logic [31:0] RD1_E = 0, RD2_E = 0, Imm_Ext_E = 0, PCE = 0, PCPlus4E = 0, ResultW = 0;
    logic [4:0]  RD_E = 0;
    logic [1:0]  ForwardA_E = 0, ForwardB_E = 0;
    logic        PCSrcE, RegWriteM, MemWriteM, ResultSrcM;
    logic [31:0] PCTargetE, ALU_ResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RD_M;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] model_prev = 32'h0;
    vec_t tbl [16];

    always #5 clk = ~clk;

    execute_cycle dut (
        .clk(clk), .rst(rst_n),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input int idx, input logic [2:0] op, input logic [31:0] a, b, imm,
                                 input logic alusrc, br, input logic [31:0] pc,
                                 input logic [1:0] fa, fb, input logic [31:0] resw,
                                 input logic [31:0] exp_alu, exp_wd, input logic exp_pcsrc,
                                 input logic [31:0] exp_tgt);
        vec_t v;
        logic [31:0] iv;
        iv = idx;
        v.regw = iv[0]; v.memw = iv[1]; v.ressrc = iv[2]; v.rd = iv[4:0] + 5'd3;
        v.op = op; v.a = a; v.b = b; v.imm = imm; v.alusrc = alusrc; v.br = br;
        v.pc = pc; v.pc4 = pc + 32'd4; v.fa = fa; v.fb = fb; v.resw = resw;
        v.exp_alu = exp_alu; v.exp_wd = exp_wd; v.exp_pcsrc = exp_pcsrc; v.exp_tgt = exp_tgt;
        return v;
    endfunction

    // Reference: arithmetic on integers straight from the operation rules
    function automatic vec_t model(input vec_t v, input logic [31:0] prev);
        longint sa, sb, r;
        logic [31:0] opa, opb, srcb;
        opa = v.a; opb = v.b;
`ifdef EXEC_FWD_EN
        if (v.fa == 2'd1) opa = v.resw; else if (v.fa == 2'd2) opa = prev;
        if (v.fb == 2'd1) opb = v.resw; else if (v.fb == 2'd2) opb = prev;
`endif
        srcb = v.alusrc ? v.imm : opb;
        sa = longint'($signed(opa)); sb = longint'($signed(srcb));
        case (v.op)
            3'd0: r = sa + sb;
            3'd1: r = sa - sb;
            3'd2: r = longint'(opa & srcb);
            3'd3: r = longint'(opa | srcb);
            3'd5: r = (sa < sb) ? 1 : 0;
            default: r = 0;
        endcase
        v.exp_alu = r[31:0];
        v.exp_wd = opb;
        v.exp_pcsrc = v.br && (r[31:0] == 32'h0);
        v.exp_tgt = v.pc + v.imm;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        RegWriteE = v.regw; ALUSrcE = v.alusrc; MemWriteE = v.memw; ResultSrcE = v.ressrc;
        BranchE = v.br; ALUControlE = v.op; RD1_E = v.a; RD2_E = v.b; Imm_Ext_E = v.imm;
        RD_E = v.rd; PCE = v.pc; PCPlus4E = v.pc4; ForwardA_E = v.fa; ForwardB_E = v.fb;
        ResultW = v.resw;
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        @(negedge clk);
        drive(v);
        n_vec++;
        #1;
        chk({tag, " PCSrcE"}, {31'h0, PCSrcE}, {31'h0, v.exp_pcsrc});
        chk({tag, " PCTargetE"}, PCTargetE, v.exp_tgt);
        @(posedge clk);
        #1;
        chk({tag, " ALU_ResultM"}, ALU_ResultM, v.exp_alu);
        chk({tag, " WriteDataM"}, WriteDataM, v.exp_wd);
        chk({tag, " RegWriteM"}, {31'h0, RegWriteM}, {31'h0, v.regw});
        chk({tag, " MemWriteM"}, {31'h0, MemWriteM}, {31'h0, v.memw});
        chk({tag, " ResultSrcM"}, {31'h0, ResultSrcM}, {31'h0, v.ressrc});
        chk({tag, " RD_M"}, {27'h0, RD_M}, {27'h0, v.rd});
        chk({tag, " PCPlus4M"}, PCPlus4M, v.pc4);
        model_prev = v.exp_alu;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " rst ALU_ResultM"}, ALU_ResultM, 32'h0);
        chk({tag, " rst WriteDataM"}, WriteDataM, 32'h0);
        chk({tag, " rst PCPlus4M"}, PCPlus4M, 32'h0);
        chk({tag, " rst ctrl"}, {28'h0, RegWriteM, MemWriteM, ResultSrcM, 1'b0}, 32'h0);
        chk({tag, " rst RD_M"}, {27'h0, RD_M}, 32'h0);
        chk({tag, " rst PCSrcE"}, {31'h0, PCSrcE}, 32'h0);
    endtask

    initial begin
        vec_t v;
        logic [31:0] fa7, fa9, fa10, wd8, wd10;
`ifdef EXEC_FWD_EN
        fa7 = 32'd8; wd8 = 32'd9; fa9 = 32'h12; fa10 = 32'h13; wd10 = 32'h12;
`else
        fa7 = 32'd51; wd8 = 32'd3; fa9 = 32'd3; fa10 = 32'd6; wd10 = 32'd5;
`endif
        //            idx op    a            b          imm          src br pc      fa fb resw   alu           wd     pcs tgt
        tbl[0]  = mkv(0,  3'd0, 32'hFFFFFFFF, 32'd1,     32'd0,        0, 0, 32'h0,  0, 0, 32'h0, 32'h0,        32'd1, 0, 32'h0);
        tbl[1]  = mkv(1,  3'd1, 32'hFFFFFFFF, 32'd1,     32'd0,        0, 0, 32'h0,  0, 0, 32'h0, 32'hFFFFFFFE, 32'd1, 0, 32'h0);
        tbl[2]  = mkv(2,  3'd5, 32'hFFFFFFFF, 32'd1,     32'd0,        0, 0, 32'h0,  0, 0, 32'h0, 32'h1,        32'd1, 0, 32'h0);
        tbl[3]  = mkv(3,  3'd0, 32'd100,      32'd7,     32'd20,       1, 0, 32'h100,0, 0, 32'h0, 32'd120,      32'd7, 0, 32'h114);
        tbl[4]  = mkv(4,  3'd1, 32'd5,        32'd5,     32'hFFFFFFF8, 0, 1, 32'h40, 0, 0, 32'h0, 32'h0,        32'd5, 1, 32'h38);
        tbl[5]  = mkv(5,  3'd1, 32'd5,        32'd6,     32'hFFFFFFF8, 0, 1, 32'h40, 0, 0, 32'h0, 32'hFFFFFFFF, 32'd6, 0, 32'h38);
        tbl[6]  = mkv(6,  3'd0, 32'd3,        32'd4,     32'd0,        0, 0, 32'h0,  0, 0, 32'h0, 32'd7,        32'd4, 0, 32'h0);
        tbl[7]  = mkv(7,  3'd0, 32'd50,       32'd1,     32'd0,        0, 0, 32'h0,  2, 0, 32'h0, fa7,          32'd1, 0, 32'h0);
        tbl[8]  = mkv(8,  3'd0, 32'd2,        32'd3,     32'd0,        1, 0, 32'h0,  0, 1, 32'd9, 32'd2,        wd8,   0, 32'h0);
        tbl[9]  = mkv(9,  3'd0, 32'd1,        32'd2,     32'd0,        0, 0, 32'h0,  1, 0, 32'h10,fa9,          32'd2, 0, 32'h0);
        tbl[10] = mkv(10, 3'd0, 32'd1,        32'd5,     32'd0,        0, 0, 32'h0,  0, 2, 32'h0, fa10,         wd10,  0, 32'h0);
        tbl[11] = mkv(11, 3'd0, 32'd4,        32'd4,     32'd0,        0, 0, 32'h0,  3, 3, 32'hAA,32'd8,        32'd4, 0, 32'h0);
        tbl[12] = mkv(12, 3'd6, 32'd5,        32'd3,     32'd0,        0, 1, 32'h0,  0, 0, 32'h0, 32'h0,        32'd3, 1, 32'h0);
        tbl[13] = mkv(13, 3'd4, 32'd5,        32'd3,     32'd0,        0, 0, 32'h0,  0, 0, 32'h0, 32'h0,        32'd3, 0, 32'h0);
        tbl[14] = mkv(14, 3'd2, 32'hF0F0,     32'hFF00,  32'd0,        0, 0, 32'h0,  0, 0, 32'h0, 32'hF000,     32'hFF00, 0, 32'h0);
        tbl[15] = mkv(15, 3'd3, 32'hF0F0,     32'hFF00,  32'd0,        0, 0, 32'h0,  0, 0, 32'h0, 32'hFFF0,     32'hFF00, 0, 32'h0);

        // Power-on reset with a would-be taken branch on the inputs
        v = mkv(7, 3'd1, 32'd9, 32'd9, 32'h10, 0, 1, 32'h200, 0, 0, 32'h0, 32'h0, 32'd9, 1, 32'h210);
        drive(v);
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        chk_reset_outputs("por");
        chk("por PCTargetE", PCTargetE, 32'h210);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        chk("release ALU_ResultM", ALU_ResultM, 32'h0);
        chk("release WriteDataM", WriteDataM, 32'd9);
        chk("release RD_M", {27'h0, RD_M}, {27'h0, v.rd});
        chk("release PCPlus4M", PCPlus4M, 32'h204);
        chk("release RegWriteM", {31'h0, RegWriteM}, 32'h1);
        model_prev = 32'h0;

        for (int i = 0; i < 16; i++) apply_vec($sformatf("tbl%0d", i), tbl[i]);

        // Asynchronous reset between edges discards the latched instruction
        v = mkv(7, 3'd0, 32'd11, 32'd22, 32'd0, 0, 0, 32'h80, 0, 0, 32'h0, 32'd33, 32'd22, 0, 32'h80);
        apply_vec("pre_async", v);
        v = mkv(7, 3'd1, 32'd3, 32'd3, 32'd0, 0, 1, 32'h0, 0, 0, 32'h0, 32'h0, 32'd3, 1, 32'h0);
        @(negedge clk);
        drive(v);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        chk_reset_outputs("async");
        @(posedge clk);
        #1;
        chk_reset_outputs("async_edge");
        @(negedge clk);
        rst_n = 1'b1;
        model_prev = 32'h0;
        // After reset, forward-from-MEM must see zero
        v = mkv(5, 3'd0, 32'd1, 32'd2, 32'd0, 0, 0, 32'h0, 2, 2, 32'h0, 32'h0, 32'h0, 0, 32'h0);
        v = model(v, model_prev);
        apply_vec("post_rst_fwd", v);

        for (int i = 0; i < 300; i++) begin
            v.regw = 1'($urandom); v.memw = 1'($urandom); v.ressrc = 1'($urandom);
            v.alusrc = 1'($urandom); v.br = 1'($urandom); v.op = 3'($urandom);
            v.a = $urandom; v.b = $urandom; v.imm = $urandom; v.pc = $urandom;
            v.pc4 = v.pc + 32'd4; v.rd = 5'($urandom); v.fa = 2'($urandom);
            v.fb = 2'($urandom); v.resw = $urandom;
            if ($urandom_range(3) == 0) v.b = v.a;
            if ($urandom_range(7) == 0) v.a = $urandom_range(3) - 1;
            v = model(v, model_prev);
            apply_vec($sformatf("rnd%0d", i), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
